// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the FSM state encoding and the default parameter values.
package pipe_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT_DEF = 255;
    localparam int unsigned CNT_W_DEF       = 16;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the pipeline performance counters.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset, clears count
//   inc   - add one this cycle (ignored once count is all-ones)
//   count - current counter value
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: memory-stall FSM with timeout, branch flush and RAW
// hazard stall decode, status-write gating and stall/flush performance
// counters.
// Ports:
//   clk, rst                      - clock and synchronous active-low reset
//   hazard                        - RAW hazard on the ID instruction
//   branch_taken, exe_s           - EXE-stage branch outcome and S bit
//   mem_req, mem_ready            - MEM-stage access request / completion
//   freeze_if..freeze_mem         - hold PC, IF/ID, ID/EXE, EXE/MEM
//   flush_id, flush_exe           - bubble IF/ID, ID/EXE
//   s_en                          - gated status-register write enable
//   mem_err                       - memory timeout (sticky until reset)
//   stall_cnt, flush_cnt          - saturating performance counters
//   state                         - FSM state
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard,
    input  logic             branch_taken,
    input  logic             exe_s,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             freeze_if,
    output logic             freeze_id,
    output logic             freeze_exe,
    output logic             freeze_mem,
    output logic             flush_id,
    output logic             flush_exe,
    output logic             s_en,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_e              state_q;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                branch_owed;
    logic                mem_stall;
    logic                do_branch;

    // Stall / flush decode; priority is memory stall, branch, hazard.
    always_comb begin
        mem_stall  = 1'b0;
        do_branch  = 1'b0;
        freeze_if  = 1'b0;
        freeze_id  = 1'b0;
        freeze_exe = 1'b0;
        freeze_mem = 1'b0;
        flush_id   = 1'b0;
        flush_exe  = 1'b0;
        s_en       = 1'b0;

        mem_stall = ((state_q == ST_RUN) && mem_req && !mem_ready) ||
                    ((state_q == ST_MEM_WAIT) && !mem_ready);
        // A branch seen while frozen is still owed once the pipe moves.
        do_branch = (branch_taken || branch_owed) && !mem_stall;

        if (rst) begin
            if ((state_q == ST_ERR) || mem_stall) begin
                freeze_if  = 1'b1;
                freeze_id  = 1'b1;
                freeze_exe = 1'b1;
                freeze_mem = 1'b1;
            end else if (do_branch) begin
                flush_id  = 1'b1;
                flush_exe = 1'b1;
            end else if (hazard) begin
                freeze_if = 1'b1;
                freeze_id = 1'b1;
                flush_exe = 1'b1;
            end
            s_en = exe_s && !freeze_exe && (state_q != ST_ERR);
        end
    end

    // Memory-wait FSM with timeout counter and owed-branch flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            wait_cnt    <= '0;
            branch_owed <= 1'b0;
        end else begin
            branch_owed <= mem_stall && (branch_owed || branch_taken);
            case (state_q)
                ST_RUN: begin
                    if (mem_req && !mem_ready) begin
                        state_q  <= ST_MEM_WAIT;
                        wait_cnt <= '0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready) begin
                        state_q <= ST_RUN;
                    end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
                        state_q <= ST_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

    assign mem_err = (state_q == ST_ERR);
    assign state   = state_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_if),
        .count (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_id),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus random stimulus, all
// checked against a behavioural model of the control rules.
module tb_pipe_ctrl;

    localparam int unsigned TO   = 4;
    localparam int unsigned CW   = 4;
    localparam int unsigned CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          hazard = 1'b0;
    logic          branch_taken = 1'b0;
    logic          exe_s = 1'b0;
    logic          mem_req = 1'b0;
    logic          mem_ready = 1'b0;
    logic          freeze_if, freeze_id, freeze_exe, freeze_mem;
    logic          flush_id, flush_exe, s_en, mem_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [1:0]    state;

    always #5 clk = ~clk;

    pipe_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .exe_s        (exe_s),
        .mem_req      (mem_req),
        .mem_ready    (mem_ready),
        .freeze_if    (freeze_if),
        .freeze_id    (freeze_id),
        .freeze_exe   (freeze_exe),
        .freeze_mem   (freeze_mem),
        .flush_id     (flush_id),
        .flush_exe    (flush_exe),
        .s_en         (s_en),
        .mem_err      (mem_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .state        (state)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=running, 1=waiting on memory, 2=dead.
    int m_mode    = 0;
    int m_waited  = 0;   // MEM_WAIT cycles spent without ready
    bit m_owed    = 1'b0;
    int m_stalls  = 0;
    int m_flushes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode    = 0;
        m_waited  = 0;
        m_owed    = 1'b0;
        m_stalls  = 0;
        m_flushes = 0;
    endtask

    // One clock cycle: drive inputs, check against the model, clock, advance model.
    task automatic step(input bit r, input bit hz, input bit bt, input bit es,
                        input bit mr, input bit rdy);
        bit stall, fi, fd, fe, fm, fli, fle, se, me;
        rst = r; hazard = hz; branch_taken = bt; exe_s = es;
        mem_req = mr; mem_ready = rdy;
        #2;
        stall = 0; fi = 0; fd = 0; fe = 0; fm = 0; fli = 0; fle = 0; se = 0;
        if (m_mode != 2)
            stall = (m_mode == 0 && mr && !rdy) || (m_mode == 1 && !rdy);
        if (r) begin
            if (m_mode == 2 || stall) begin
                fi = 1; fd = 1; fe = 1; fm = 1;
            end else if (bt || m_owed) begin
                fli = 1; fle = 1;
            end else if (hz) begin
                fi = 1; fd = 1; fle = 1;
            end
            se = es && !fe && (m_mode != 2);
        end
        me = (m_mode == 2);
        check("ctl", 32'({freeze_if, freeze_id, freeze_exe, freeze_mem,
                          flush_id, flush_exe, s_en, mem_err}),
                     32'({fi, fd, fe, fm, fli, fle, se, me}));
        check("state", 32'(state), 32'(m_mode));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stalls));
        check("flush_cnt", 32'(flush_cnt), 32'(m_flushes));
        @(posedge clk);
        #1;
        if (!r) begin
            model_reset();
        end else begin
            if (fi && m_stalls < int'(CMAX)) m_stalls++;
            if (fli && m_flushes < int'(CMAX)) m_flushes++;
            m_owed = stall && (m_owed || bt);
            if (m_mode == 0) begin
                if (mr && !rdy) begin
                    m_mode   = 1;
                    m_waited = 0;
                end
            end else if (m_mode == 1) begin
                if (rdy) begin
                    m_mode = 0;
                end else begin
                    m_waited++;
                    if (m_waited > int'(TO)) m_mode = 2;
                end
            end
        end
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        // Initial reset without checks: DUT state is unknown before it.
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        check("rst_state", 32'(state), 32'(0));
        check("rst_mem_err", 32'(mem_err), 32'(0));
        check("rst_stall_cnt", 32'(stall_cnt), 32'(0));
        check("rst_flush_cnt", 32'(flush_cnt), 32'(0));

        // Two hazard cycles.
        step(1, 1, 0, 1, 0, 0);
        step(1, 1, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("hz2_stall_cnt", 32'(stall_cnt), 32'(2));

        // Branch and hazard together resolve as a branch.
        do_reset();
        step(1, 1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("br_hz_flush_cnt", 32'(flush_cnt), 32'(1));
        check("br_hz_stall_cnt", 32'(stall_cnt), 32'(0));

        // Memory not ready for three cycles, then ready.
        do_reset();
        step(1, 0, 0, 1, 1, 0);
        check("mw_enter", 32'(state), 32'(1));
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 0);
        step(1, 0, 0, 1, 1, 1);
        check("mw_exit", 32'(state), 32'(0));
        check("mw_stall_cnt", 32'(stall_cnt), 32'(3));

        // Timeout into ERR, sticky until reset.
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 0, 0, 1, 1, 0);
        check("to_state", 32'(state), 32'(2));
        check("to_mem_err", 32'(mem_err), 32'(1));
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 0, 1);
        check("err_hold", 32'(state), 32'(2));
        do_reset();
        check("err_rst_state", 32'(state), 32'(0));
        check("err_rst_mem_err", 32'(mem_err), 32'(0));

        // Branch held across a two-cycle memory stall flushes once on release.
        do_reset();
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 1, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("br_mw_flush_cnt", 32'(flush_cnt), 32'(1));

        // Branch pulsed only during the stall is still flushed once.
        do_reset();
        step(1, 0, 1, 0, 1, 0);
        step(1, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1, 1);
        step(1, 0, 0, 0, 0, 0);
        check("br_owed_flush_cnt", 32'(flush_cnt), 32'(1));

        // Counter saturation.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 1, 0, 0, 0, 0);
        check("sat_stall_cnt", 32'(stall_cnt), 32'(15));
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 1, 0, 0, 0);
        check("sat_flush_cnt", 32'(flush_cnt), 32'(15));

        // Random traffic with occasional reset.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 99) >= 2,
                 $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 35);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255, SHALL set the maximum MEM_WAIT cycles before the error state is entered.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of the performance counters.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 hazard  input  1  SHALL flag a RAW hazard, meaning the ID instruction reads a dest pending in EXE or MEM.
REQ-006 branch_taken  input  1  SHALL be the EXE-stage branch_taken.
REQ-007 exe_s  input  1  SHALL be the S bit of the EXE instruction.
REQ-008 mem_req  input  1  SHALL be MEM_R_out|MEM_W_out of the instruction in MEM.
REQ-009 mem_ready  input  1  SHALL be the data-memory completion strobe.
REQ-010 freeze_if, freeze_id, freeze_exe, freeze_mem  output  1 each  SHALL hold the PC and the IF/ID, ID/EXE and EXE/MEM registers respectively.
REQ-011 flush_id, flush_exe  output  1 each  SHALL clear the IF/ID and ID/EXE registers to a bubble.
REQ-012 s_en  output  1  SHALL be the gated S to the status register.
REQ-013 mem_err  output  1  SHALL signal a memory timeout.
REQ-014 stall_cnt, flush_cnt  output  CNT_W each  SHALL be the performance counters.
REQ-015 state  output  2  SHALL expose the FSM state.

Function
REQ-016 The FSM SHALL have states RUN=0, MEM_WAIT=1 and ERR=2.
REQ-017 RUN->MEM_WAIT SHALL occur when mem_req=1 and mem_ready=0; freezes SHALL assert combinationally in that same cycle.
REQ-018 MEM_WAIT->RUN SHALL occur on the first cycle with mem_ready=1; freezes SHALL drop combinationally in that cycle, so the pipeline advances on that edge.
REQ-019 A wait counter SHALL clear on MEM_WAIT entry and increment each MEM_WAIT cycle; counter==MEM_TIMEOUT with mem_ready=0 SHALL move the FSM to ERR.
REQ-020 ERR SHALL be exited only by reset; in ERR all four freezes and mem_err SHALL be 1.
REQ-021 Priority SHALL be memory stall > branch flush > hazard stall.
REQ-022 Memory stall (RUN with mem_req&!mem_ready, or MEM_WAIT without mem_ready) SHALL assert all four freezes and both flushes=0.
REQ-023 A branch SHALL be taken only when branch_taken=1 and no memory stall; it SHALL assert flush_id=flush_exe=1 with no freezes.
REQ-024 A branch held during a memory stall SHALL flush in the first unfrozen cycle, exactly once.
REQ-025 Hazard stall (hazard=1, no branch, no memory stall) SHALL assert freeze_if=freeze_id=1 and flush_exe=1.
REQ-026 A simultaneous hazard and branch SHALL be resolved as a branch.
REQ-027 s_en SHALL equal exe_s & !freeze_exe & !ERR.
REQ-028 stall_cnt SHALL +1 each cycle freeze_if=1.
REQ-029 flush_cnt SHALL +1 each cycle flush_id=1.
REQ-030 Both counters SHALL saturate at all-ones, never wrapping.

Reset
REQ-031 rst=0 at a clock edge SHALL give state=RUN, wait counter=0, stall_cnt=0, flush_cnt=0 and mem_err=0.
REQ-032 Reset SHALL take effect in any state, including mid-MEM_WAIT and ERR.
REQ-033 While rst=0, all freeze and flush outputs and s_en SHALL be 0.

Structure
REQ-034 Package pipe_ctrl_pkg SHALL hold the state encoding and the MEM_TIMEOUT/CNT_W defaults.
REQ-035 One sub-module, sat_counter (parameterised width, sync active-low rst, inc input), SHALL implement both performance counters.
REQ-036 The FSM and all freeze/flush decode SHALL live in pipe_ctrl itself.

Verification
REQ-037 Scenario: hazard=1 for 2 cycles -> freeze_if=freeze_id=flush_exe=1 in both cycles; stall_cnt=2.
REQ-038 Scenario: branch_taken=1 with hazard=1 in the same cycle -> flush_id=flush_exe=1, no freezes; flush_cnt=1, stall_cnt=0.
REQ-039 Scenario: mem_req=1, mem_ready low for 3 cycles, then high -> state=MEM_WAIT for 3 cycles with all freezes=1; state=RUN on the ready cycle; stall_cnt=3.
REQ-040 Scenario: MEM_TIMEOUT=4, mem_ready held 0 -> ERR after 5 MEM_WAIT cycles; mem_err=1 and s_en=0 until rst=0.
REQ-041 Scenario: branch_taken=1 during a 2-cycle memory stall -> no flush while frozen; one flush cycle when released; flush_cnt=1.
REQ-042 Scenario: CNT_W=4 with 20 hazard cycles -> stall_cnt=15, held, no wrap.
